// File: rtl/powlib_pkg.sv
// Shared definitions for the powlib blocks: arbiter FSM states and a ceil-log2 helper.
package powlib_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } rrarb_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/powlib_flipflop.sv
// Generic register with reset value INIT, optional async reset (EAR) and optional load enable (EVLD).
module powlib_flipflop #(
    parameter int           W    = 1,
    parameter logic [W-1:0] INIT = '0,
    parameter bit           EAR  = 1'b0,
    parameter bit           EVLD = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vld,
    input  logic [W-1:0] idata,
    output logic [W-1:0] odata
);

    logic en;
    assign en = vld || !EVLD;

    generate
        if (EAR) begin : g_async
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     odata <= INIT;
                else if (en) odata <= idata;
            end
        end else begin : g_sync
            always_ff @(posedge clk) begin
                if (rst)     odata <= INIT;
                else if (en) odata <= idata;
            end
        end
    endgenerate

endmodule

// File: rtl/powlib_rrarb.sv
// Round-robin N:1 arbiter with a one-entry registered output stage.
// Optional burst locking compiled in with POWLIB_RRARB_LOCK_EN (adds the lck port).
module powlib_rrarb
    import powlib_pkg::*;
#(
    parameter int           W    = 8,
    parameter int           N    = 4,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic            clk,
    input  logic            rst,
`ifdef POWLIB_RRARB_LOCK_EN
    input  logic [N-1:0]    lck,
`endif
    input  logic [N*W-1:0]  idata,
    input  logic [N-1:0]    ivld,
    output logic [N-1:0]    irdy,
    output logic [W-1:0]    odata,
    output logic            ovld,
    output logic [((N>1) ? clog2(N) : 1)-1:0] osel,
    input  logic            ordy
);

    localparam int IW = (N > 1) ? clog2(N) : 1;

    logic [IW-1:0]   ptr, g, nptr, owner;
    logic            any, ld, acc, lock_act;
    logic [W+IW-1:0] dnext, oq;

    function automatic int wrap_idx(input int a);
        return (a >= N) ? a - N : a;
    endfunction

    assign ld = !ovld || ordy;

    // Grant: the locked owner, or the first valid requester at or after ptr.
    always_comb begin
        g   = '0;
        any = 1'b0;
        if (lock_act) begin
            g   = owner;
            any = ivld[owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!any && ivld[wrap_idx(int'(ptr) + k)]) begin
                    g   = IW'(wrap_idx(int'(ptr) + k));
                    any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        irdy = '0;
        if (!rst && ld && any) irdy[g] = 1'b1;
    end

    assign acc  = |irdy;
    assign nptr = (int'(g) == N - 1) ? '0 : g + IW'(1);

    // The register loads on every ld; an idle load recirculates so odata/osel hold.
    assign dnext = acc ? {g, idata[int'(g)*W +: W]} : {osel, odata};

    powlib_flipflop #(
        .W    (W + IW),
        .INIT ({IW'(0), INIT}),
        .EAR  (1'b0),
        .EVLD (1'b1)
    ) u_oreg (
        .clk   (clk),
        .rst   (rst),
        .vld   (ld),
        .idata (dnext),
        .odata (oq)
    );

    assign {osel, odata} = oq;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovld <= 1'b0;
            ptr  <= '0;
        end else if (ld) begin
            ovld <= acc;
            if (acc) ptr <= nptr;
        end
    end

`ifdef POWLIB_RRARB_LOCK_EN
    rrarb_state_t    state_q, state_d;
    logic [IW-1:0]   owner_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
            owner   <= '0;
        end else begin
            state_q <= state_d;
            owner   <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner;
        case (state_q)
            ARB: begin
                if (acc && lck[g]) begin
                    state_d = LOCK;
                    owner_d = g;
                end
            end
            LOCK: begin
                if (acc && !lck[owner]) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    assign lock_act = (state_q == LOCK);
`else
    assign owner    = '0;
    assign lock_act = 1'b0;
`endif

endmodule

// File: doc/powlib_rrarb.md
POWLIB_RRARB -- requirements
Module: powlib_rrarb

Interface
REQ-001 SHALL have parameter W, default 8: data width per requester.
REQ-002 SHALL have parameter N, default 4: number of requesters (N>=1).
REQ-003 SHALL have parameter INIT [W-1:0], default 0: reset value of odata.
REQ-004 SHALL derive localparam IW = (N>1) ? clog2(N) : 1 as the grant-index width.
REQ-005 SHALL have port clk, input, 1: clock; the block uses one clock only.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port idata, input, N*W: requester data; requester i occupies bits [i*W +: W].
REQ-008 SHALL have port ivld, input, N: per-requester valid.
REQ-009 SHALL have port irdy, output, N: per-requester ready.
REQ-010 SHALL have port odata, output, W: registered output data.
REQ-011 SHALL have port ovld, output, 1: output valid.
REQ-012 SHALL have port osel, output, IW: index of the requester that sourced odata.
REQ-013 SHALL have port ordy, input, 1: downstream ready.

Function
REQ-014 SHALL define a beat as accepted on input i when ivld[i] && irdy[i], and on the output when ovld && ordy.
REQ-015 SHALL use a one-entry output register with load enable ld = !ovld || ordy.
REQ-016 SHALL select grant g as the first index with ivld set, searching ptr, ptr+1, ... modulo N.
REQ-017 SHALL drive irdy[i] = ld && (i==g) && (ivld nonzero); at most one irdy bit high per cycle.
REQ-018 SHALL, on an accepted input beat, load odata<=idata[g], osel<=g, ovld<=1, ptr<=(g+1) mod N on the next edge.
REQ-019 SHALL give a latency of 1 cycle from input acceptance to ovld.
REQ-020 SHALL clear ovld on the next edge when ld=1 and ivld=0; odata and osel hold.
REQ-021 SHALL hold odata, osel, ovld and ptr unchanged when ld=0, regardless of ivld.
REQ-022 SHALL sustain full throughput: one beat per cycle when ordy stays 1.
REQ-023 SHALL wrap ptr from N-1 to 0; with N=1, grant is always 0 and ptr stays 0.
REQ-024 SHALL NOT let irdy depend on any ivld bit other than through grant selection; there is no combinational path from idata.

Reset
REQ-025 SHALL set, while rst=1 at a clk edge: ovld=0, odata=INIT, osel=0, ptr=0, FSM=ARB.
REQ-026 SHALL force irdy=0 combinationally while rst=1.
REQ-027 SHALL abandon any in-flight lock when rst is asserted mid-operation; no beat is accepted in that cycle.

Configuration
REQ-028 SHALL compile in grant locking with macro POWLIB_RRARB_LOCK_EN.
REQ-029 SHALL, with POWLIB_RRARB_LOCK_EN defined, add port lck, input, N (per-requester burst lock) and a two-state FSM ARB/LOCK.
REQ-030 SHALL, with the macro, move ARB->LOCK on an accepted beat from g with lck[g]=1, latching g as the lock owner.
REQ-031 SHALL, in LOCK, force grant to the owner only; other requesters see irdy=0 even when the owner's ivld=0 (bubble).
REQ-032 SHALL, in LOCK, return to ARB on an owner beat accepted with lck=0, setting ptr<=(owner+1) mod N.
REQ-033 SHALL, without the macro, have no lck port, always behave as ARB and re-arbitrate every beat.

Structure
REQ-034 SHALL place the FSM state typedef (ARB, LOCK) and a clog2 helper function in shared package powlib_pkg.
REQ-035 SHALL implement the output register {osel, odata} as one powlib_flipflop instance: W+IW bits, INIT={0, INIT}, EAR=0, EVLD=1, vld=ld; ovld is kept in a separate register.

Verification (N=4, W=8, INIT=8'hA5)
REQ-036 SHALL check reset: rst=1 for 2 cycles with ivld=4'hF -> irdy=0 throughout, and after release ovld=0, odata=8'hA5, osel=0.
REQ-037 SHALL check rotation: ivld=4'hF, idata={8'h33,8'h22,8'h11,8'h00}, ordy=1 -> osel sequence 0,1,2,3,0 on consecutive cycles, odata 8'h00,8'h11,8'h22,8'h33,8'h00, each one cycle after grant.
REQ-038 SHALL check backpressure: ovld=1 and ordy=0 for 3 cycles -> irdy=0 and odata/osel stable; ordy=1 -> the next grant continues from the stored ptr.
REQ-039 SHALL check wrap: ptr=3, ivld=4'b0101 -> grant 0, then ptr=1 -> grant 2, then grant 0.
REQ-040 SHALL check lock (macro on): ivld=4'hF, lck[1]=1 for 3 beats then 0 -> osel=1 for 4 consecutive beats then osel=2; rst asserted during LOCK -> ARB with grant 0 after release.
